// File: rtl/lookahead_sub_serial_pkg.sv
// Shared arithmetic definitions for the nibble-serial subtractor.
// State encoding, slice width and nibble-count helper.
package lookahead_sub_serial_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int nibbles(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/lookahead_sub_serial_slice.sv
// Combinational 4-bit borrow-lookahead slice computing x + y_inv + cin.
// Carries are flattened generate/propagate sums of products.
module sub_slice_4bit
  import lookahead_sub_serial_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y_inv,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y_inv;
  assign p = x ^ y_inv;

  assign c[0] = g[0]
              | (p[0] & cin);
  assign c[1] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[2] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[3] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ {c[2:0], cin};
  assign cout = c[3];

endmodule

// File: rtl/lookahead_sub_serial.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit slice per clock.
// Valid/ready handshakes on operand and result sides.
module lookahead_sub_serial
  import lookahead_sub_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = nibbles(WIDTH);
  localparam int KW = $clog2(N);

  state_t state;
  state_t state_n;

  logic [KW-1:0]    k;
  logic [KW+1:0]    idx;
  logic             last;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;

  logic [SLICE_W-1:0] sx;
  logic [SLICE_W-1:0] sy;
  logic [SLICE_W-1:0] ss;
  logic               sc;

  assign idx  = {k, 2'b00};
  assign last = (k == KW'(N - 1));
  assign sx   = a_q[idx +: SLICE_W];
  assign sy   = ~b_q[idx +: SLICE_W];

  sub_slice_4bit u_slice (
    .x     (sx),
    .y_inv (sy),
    .cin   (carry),
    .s     (ss),
    .cout  (sc)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = RUN;
      RUN:  if (last) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      carry  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        carry <= ~bin;
        k     <= '0;
      end else if (state == RUN) begin
        diff_q[idx +: SLICE_W] <= ss;
        carry <= sc;
        k     <= last ? '0 : k + KW'(1);
        // Flags settle together with the top nibble.
        if (last) begin
          bout_q <= ~sc;
          ovf_q  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                  & (ss[SLICE_W-1] ^ a_q[WIDTH-1]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = (state == DONE) && (diff_q == '0);

endmodule

// File: tb/tb_lookahead_sub_serial.sv
// Self-checking bench: directed vectors plus random traffic on 16- and 8-bit
// instances, scored against an integer model of a - b - bin.
module tb_lookahead_sub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv, ir, ov, ordy, bin16, bo, of, z;
  logic [15:0] a16, b16, d16;
  logic        iv8, ir8, ov8, ordy8, bin8, bo8, of8, z8;
  logic [7:0]  a8, b8, d8;

  int checks = 0;
  int errors = 0;

  logic [32:0] q16[$];
  logic [16:0] q8[$];

  lookahead_sub_serial #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir),
    .a(a16), .b(b16), .bin(bin16),
    .out_valid(ov), .out_ready(ordy),
    .diff(d16), .bout(bo), .ovf(of), .zero(z)
  );

  lookahead_sub_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(ordy8),
    .diff(d8), .bout(bo8), .ovf(of8), .zero(z8)
  );

  // Returns {zero, ovf, bout, diff[15:0]} for a w-bit a - b - bin.
  function automatic logic [18:0] model(input int w,
                                        input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic bin);
    longint m, half, ua, ub, r, sa, sb, sr;
    logic [15:0] d;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    r    = ua - ub - longint'(bin);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    sr   = sa - sb - longint'(bin);
    d    = 16'(r & m);
    return {d == 16'h0, (sr < -half) || (sr >= half), r < 0, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q16.delete();
      q8.delete();
    end else begin
      if (ov && ordy && q16.size() > 0) void'(q16.pop_front());
      if (iv && ir) q16.push_back({bin16, b16, a16});
      if (ov8 && ordy8 && q8.size() > 0) void'(q8.pop_front());
      if (iv8 && ir8) q8.push_back({bin8, b8, a8});
    end
  end

  always @(negedge clk) begin
    logic [18:0] e;
    if (!rst && ov) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL spurious16: out_valid=1 required 0");
      end else begin
        e = model(16, q16[0][15:0], q16[0][31:16], q16[0][32]);
        if ({ir, z, of, bo, d16} !== {1'b0, e}) begin
          errors++;
          $display("FAIL model16: got %h required %h",
                   {ir, z, of, bo, d16}, {1'b0, e});
        end
      end
    end
    if (!rst && ov8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL spurious8: out_valid=1 required 0");
      end else begin
        e = model(8, {8'h0, q8[0][7:0]}, {8'h0, q8[0][15:8]}, q8[0][16]);
        if ({ir8, z8, of8, bo8, d8} !== {1'b0, e[18:16], e[7:0]}) begin
          errors++;
          $display("FAIL model8: got %h required %h",
                   {ir8, z8, of8, bo8, d8}, {1'b0, e[18:16], e[7:0]});
        end
      end
    end
  end

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb,
                       input logic tbin, input logic [15:0] ed,
                       input logic eb, input logic eo, input logic ez,
                       input bit noisy, input int hold);
    int cyc;
    a16 = ta; b16 = tb; bin16 = tbin; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    cyc = 0;
    while (!ov && cyc < 20) begin
      if (noisy) begin
        a16 = 16'($urandom); b16 = 16'($urandom);
        bin16 = 1'($urandom); iv = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv = 1'b0;
    chk("latency", cyc, 4);
    chk("diff", {16'h0, d16}, {16'h0, ed});
    chk("flags", {29'h0, bo, of, z}, {29'h0, eb, eo, ez});
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold", {12'h0, ov, ir, d16, bo, of, z},
          {12'h0, 1'b1, 1'b0, ed, eb, eo, ez});
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    chk("idle_ready", {30'h0, ov, ir}, 32'h1);
  endtask

  task automatic rand16(input int n);
    int cyc;
    for (int i = 0; i < n; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
      if (i % 16 == 1) b16 = a16;
      iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      cyc = 0;
      while (!ov && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (!ov) chk("timeout16", 0, 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
    end
  endtask

  task automatic rand8(input int n);
    int cyc;
    for (int i = 0; i < n; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      if (i % 16 == 1) b8 = a8;
      iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      cyc = 0;
      while (!ov8 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (!ov8) chk("timeout8", 0, 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      ordy8 = 1'b1;
      @(posedge clk); #1;
      ordy8 = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv = 1'b0; ordy = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    iv8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset16", {12'h0, ov, ir, d16, bo, of, z}, 32'h0);
    chk("reset8", {20'h0, ov8, ir8, d8, bo8, of8, z8}, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {30'h0, ir, ir8}, 32'h3);

    run16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 0, 0);
    run16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0, 0);
    run16(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 0, 0);
    run16(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 0, 0);
    run16(16'h00FF, 16'h00FE, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1);
    run16(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0, 0);
    run16(16'hA5C3, 16'h3C5A, 1'b0, 16'h6969, 1'b0, 1'b1, 1'b0, 1, 5);

    // Reset during the second RUN cycle drops the result.
    a16 = 16'h4321; b16 = 16'h1111; bin16 = 1'b0; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_run", {12'h0, ov, ir, d16, bo, of, z}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_run_ready", {31'h0, ir}, 32'h1);
    repeat (8) begin
      @(posedge clk); #1;
      chk("no_valid_after_rst", {31'h0, ov}, 32'h0);
    end

    // in_valid together with rst latches nothing.
    rst = 1'b1; iv = 1'b1; a16 = 16'h0005; b16 = 16'h0003;
    @(posedge clk); #1;
    rst = 1'b0; iv = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("rst_wins", {30'h0, ov, ir}, 32'h1);
    end

    fork
      rand16(500);
      rand8(500);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
